// File: rtl/oam_dma_controller_pkg.sv
// gb_mem_map: shared memory-map constants and DMA state encoding
package gb_mem_map;
    localparam logic [15:0] ADDR_DMA_REG = 16'hFF46;
    localparam logic [15:0] ADDR_HRAM_LO = 16'hFF80;
    localparam logic [15:0] ADDR_HRAM_HI = 16'hFFFE;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          OAM_BYTES    = 160;
    typedef enum logic {ST_IDLE, ST_XFER} dma_state_e;
    // Pages E0-FF echo WRAM, so the source is fetched 0x20 pages lower.
    function automatic logic [7:0] dma_src_hi(input logic [7:0] v);
        return v >= 8'hE0 ? v - 8'h20 : v;
    endfunction
endpackage

// File: rtl/oam_dma_controller_slot_counter.sv
// dma_slot_counter: modulo-CYCLES_PER_BYTE counter with terminal count and sync clear
// Ports: iClock/iReset, iClear (sync clear), iEnable (count), oCount, oTerminal (count == last slot)
module dma_slot_counter #(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int W = $clog2(CYCLES_PER_BYTE)
) (
    input  logic         iClock,
    input  logic         iReset,
    input  logic         iClear,
    input  logic         iEnable,
    output logic [W-1:0] oCount,
    output logic         oTerminal
);
    logic [W-1:0] count_q;
    assign oCount = count_q;
    assign oTerminal = count_q == W'(CYCLES_PER_BYTE - 1);
    always_ff @(posedge iClock) begin
        if (iReset || iClear) count_q <= '0;
        else if (iEnable) count_q <= oTerminal ? '0 : count_q + 1'b1;
    end
endmodule

// File: rtl/oam_dma_controller.sv
// oam_dma_controller: sequences the FF46-triggered 160-byte copy into OAM
// Ports: iClock/iReset; CPU bus (iCpuAddr, iCpuWe, iCpuReadRequest, iCpuData); oDmaReg readback;
// source read port (oDmaReadRequest, oDmaReadAddr, iDmaReadData); OAM write port (oOamWe, oOamAddr, oOamData);
// oDmaActive and oCpuBusConflict status.
module oam_dma_controller #(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int READ_LATENCY    = 1,
    parameter int OAM_BYTES       = 160
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [15:0] iCpuAddr,
    input  logic        iCpuWe,
    input  logic        iCpuReadRequest,
    input  logic [7:0]  iCpuData,
    output logic [7:0]  oDmaReg,
    output logic        oDmaActive,
    output logic        oDmaReadRequest,
    output logic [15:0] oDmaReadAddr,
    input  logic [7:0]  iDmaReadData,
    output logic        oOamWe,
    output logic [7:0]  oOamAddr,
    output logic [7:0]  oOamData,
    output logic        oCpuBusConflict
);
    import gb_mem_map::*;
    localparam int SW = $clog2(CYCLES_PER_BYTE);
    dma_state_e    state_q;
    logic [7:0]    reg_q, src_q, idx_q, data_q;
    logic [SW-1:0] slot;
    logic          slot_tc, trigger, xfer, last;
    assign trigger = iCpuWe && iCpuAddr == ADDR_DMA_REG;
    assign xfer = state_q == ST_XFER;
    assign last = slot_tc && idx_q == 8'(OAM_BYTES - 1);
    // Slot count restarts on every trigger so a retrigger begins at s == 0.
    dma_slot_counter #(.CYCLES_PER_BYTE(CYCLES_PER_BYTE), .W(SW)) u_slot (
        .iClock   (iClock),
        .iReset   (iReset),
        .iClear   (trigger || !xfer),
        .iEnable  (xfer),
        .oCount   (slot),
        .oTerminal(slot_tc)
    );
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= ST_IDLE;
            reg_q   <= '0;
            src_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            // A trigger wins over end-of-transfer so back-to-back runs have no idle gap.
            if (trigger) begin
                state_q <= ST_XFER;
                reg_q   <= iCpuData;
                src_q   <= dma_src_hi(iCpuData);
                idx_q   <= '0;
            end else if (xfer && slot_tc) begin
                idx_q <= last ? idx_q : idx_q + 8'd1;
                if (last) state_q <= ST_IDLE;
            end
            if (xfer && slot == SW'(READ_LATENCY)) data_q <= iDmaReadData;
        end
    end
    assign oDmaReg = reg_q;
    assign oDmaActive = xfer;
    assign oDmaReadRequest = xfer && slot == '0;
    assign oDmaReadAddr = {src_q, idx_q};
    assign oOamWe = xfer && slot_tc;
    assign oOamAddr = idx_q;
    assign oOamData = data_q;
    assign oCpuBusConflict = xfer && (iCpuWe || iCpuReadRequest) &&
                             !(iCpuAddr >= ADDR_HRAM_LO && iCpuAddr <= ADDR_HRAM_HI);
endmodule

// File: tb/tb_oam_dma_controller.sv
// tb_oam_dma_controller: directed self-checking bench for oam_dma_controller
module tb_oam_dma_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic        we = 1'b0, rd = 1'b0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata = '0;
    logic [7:0]  dma_reg, oam_addr, oam_data;
    logic        act, rreq, oam_we, conflict;
    logic [15:0] raddr;
    int cyc = 0, checks = 0, errors = 0;
    logic [7:0] exp_hi = '0, mon_hi = '0;
    int rd_n = 0, wr_n = 0, act_n = 0, bad_rd = 0, bad_wr = 0, bad_gap = 0;
    int last_rd_cyc = 0, first_rd_cyc = -1, last_wr_cyc = 0, arm_cyc = 0;
    int prev_rd_n = 0, prev_wr_n = 0, prev_act_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    oam_dma_controller dut (
        .iClock(clk), .iReset(rst), .iCpuAddr(addr), .iCpuWe(we),
        .iCpuReadRequest(rd), .iCpuData(wdata), .oDmaReg(dma_reg),
        .oDmaActive(act), .oDmaReadRequest(rreq), .oDmaReadAddr(raddr),
        .iDmaReadData(rdata), .oOamWe(oam_we), .oOamAddr(oam_addr),
        .oOamData(oam_data), .oCpuBusConflict(conflict)
    );

    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h5A;
    endfunction

    // Source memory with one clock of read latency.
    always @(posedge clk) if (rreq) rdata <= src_byte(raddr);

    // Transfer monitor: follows the expected read/write stream since the last FF46 write.
    always @(negedge clk) begin
        if (rst) begin
            rd_n = 0;
            wr_n = 0;
            act_n = 0;
        end else begin
            if (act) act_n++;
            if (oam_we && !act) bad_wr++;
            if (rreq) begin
                if (rd_n >= 160 || raddr != {mon_hi, 8'(rd_n)}) bad_rd++;
                if (rd_n == 0) first_rd_cyc = cyc;
                else if (cyc - last_rd_cyc != 4) bad_gap++;
                last_rd_cyc = cyc;
                rd_n++;
            end
            if (oam_we) begin
                if (wr_n >= 160 || oam_addr != 8'(wr_n) || oam_data != src_byte({mon_hi, 8'(wr_n)})) bad_wr++;
                last_wr_cyc = cyc;
                wr_n++;
            end
            if (we && addr == 16'hFF46) begin
                prev_rd_n = rd_n;
                prev_wr_n = wr_n;
                prev_act_n = act_n;
                mon_hi = exp_hi;
                rd_n = 0;
                wr_n = 0;
                act_n = 0;
                arm_cyc = cyc;
                first_rd_cyc = -1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic trig_now(input logic [7:0] d, input logic [7:0] hi);
        exp_hi = hi;
        addr = 16'hFF46;
        wdata = d;
        we = 1'b1;
        tick();
        we = 1'b0;
        addr = '0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            #1;
            if (!act) break;
        end
        chk({tag, "_done"}, 32'(act), 0);
    endtask

    task automatic run_ok(input string tag);
        chk({tag, "_reads"}, rd_n, 160);
        chk({tag, "_writes"}, wr_n, 160);
        chk({tag, "_active_cycles"}, act_n, 640);
        chk({tag, "_first_read_lat"}, first_rd_cyc - arm_cyc, 1);
        chk({tag, "_last_write_lat"}, last_wr_cyc - arm_cyc, 640);
        chk({tag, "_bad_reads"}, bad_rd, 0);
        chk({tag, "_bad_writes"}, bad_wr, 0);
        chk({tag, "_bad_gaps"}, bad_gap, 0);
    endtask

    task automatic probe(input string tag, input logic [15:0] a, input logic w, input logic r, input logic exp);
        addr = a;
        we = w;
        rd = r;
        #1;
        chk(tag, 32'(conflict), 32'(exp));
        we = 1'b0;
        rd = 1'b0;
        addr = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        chk("rst_reg", 32'(dma_reg), 0);
        chk("rst_active", 32'(act), 0);
        chk("rst_rreq", 32'(rreq), 0);
        chk("rst_raddr", 32'(raddr), 0);
        chk("rst_oam_we", 32'(oam_we), 0);
        chk("rst_oam_addr", 32'(oam_addr), 0);
        chk("rst_oam_data", 32'(oam_data), 0);
        chk("rst_conflict", 32'(conflict), 0);
        rst = 1'b0;
        tick();
        // Plain transfer from C1xx with bus-conflict probes during XFER.
        trig_now(8'hC1, 8'hC1);
        chk("c1_reg", 32'(dma_reg), 32'h00C1);
        chk("c1_active", 32'(act), 1);
        chk("c1_rreq", 32'(rreq), 1);
        chk("c1_raddr", 32'(raddr), 32'hC100);
        probe("cf_rd_ff85", 16'hFF85, 1'b0, 1'b1, 1'b0);
        probe("cf_rd_c000", 16'hC000, 1'b0, 1'b1, 1'b1);
        probe("cf_rd_ff80", 16'hFF80, 1'b0, 1'b1, 1'b0);
        probe("cf_rd_fffe", 16'hFFFE, 1'b0, 1'b1, 1'b0);
        probe("cf_rd_ffff", 16'hFFFF, 1'b0, 1'b1, 1'b1);
        probe("cf_rd_ff7f", 16'hFF7F, 1'b0, 1'b1, 1'b1);
        probe("cf_wr_8000", 16'h8000, 1'b1, 1'b0, 1'b1);
        probe("cf_idle_c000", 16'hC000, 1'b0, 1'b0, 1'b0);
        wait_idle("c1");
        run_ok("c1");
        probe("cf_after_c000", 16'hC000, 1'b0, 1'b1, 1'b0);
        // Echo-area source E2 is fetched from C2xx.
        tick();
        trig_now(8'hE2, 8'hC2);
        chk("e2_reg", 32'(dma_reg), 32'h00E2);
        chk("e2_raddr", 32'(raddr), 32'hC200);
        wait_idle("e2");
        run_ok("e2");
        // Retrigger to 80xx in the cycle that writes index 50.
        tick();
        trig_now(8'h40, 8'h40);
        repeat (203) tick();
        exp_hi = 8'h80;
        addr = 16'hFF46;
        wdata = 8'h80;
        we = 1'b1;
        #1;
        chk("rt_conflict", 32'(conflict), 1);
        chk("rt_oam_we", 32'(oam_we), 1);
        chk("rt_oam_addr", 32'(oam_addr), 50);
        tick();
        we = 1'b0;
        addr = '0;
        chk("rt_active", 32'(act), 1);
        chk("rt_rreq", 32'(rreq), 1);
        chk("rt_raddr", 32'(raddr), 32'h8000);
        chk("rt_reg", 32'(dma_reg), 32'h0080);
        wait_idle("rt");
        chk("rt_prev_writes", prev_wr_n, 51);
        chk("rt_prev_reads", prev_rd_n, 51);
        run_ok("rt");
        // Reset at index 100 aborts the transfer.
        tick();
        trig_now(8'hC3, 8'hC3);
        repeat (400) tick();
        chk("rs_pre_raddr", 32'(raddr), 32'hC364);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_reg", 32'(dma_reg), 0);
        chk("rs_active", 32'(act), 0);
        chk("rs_rreq", 32'(rreq), 0);
        chk("rs_raddr", 32'(raddr), 0);
        chk("rs_oam_we", 32'(oam_we), 0);
        chk("rs_oam_data", 32'(oam_data), 0);
        repeat (20) tick();
        chk("rs_no_reads", rd_n, 0);
        chk("rs_no_writes", wr_n, 0);
        chk("rs_bad_writes", bad_wr, 0);
        // Fresh transfer after reset, then retrigger on its final write.
        trig_now(8'hDF, 8'hDF);
        chk("df_raddr", 32'(raddr), 32'hDF00);
        repeat (639) tick();
        exp_hi = 8'hC0;
        addr = 16'hFF46;
        wdata = 8'hE0;
        we = 1'b1;
        #1;
        chk("bb_oam_we", 32'(oam_we), 1);
        chk("bb_oam_addr", 32'(oam_addr), 159);
        tick();
        we = 1'b0;
        addr = '0;
        chk("bb_active", 32'(act), 1);
        chk("bb_rreq", 32'(rreq), 1);
        chk("bb_raddr", 32'(raddr), 32'hC000);
        chk("bb_reg", 32'(dma_reg), 32'h00E0);
        chk("df_writes", prev_wr_n, 160);
        chk("df_reads", prev_rd_n, 160);
        chk("df_active_cycles", prev_act_n, 640);
        wait_idle("bb");
        run_ok("bb");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
